stereo_frame_pairer: RTL and testbench

Sits between the codec IP's ADC left/right Avalon-ST sources and the recorder core. It accepts independent left and right 16-bit sample streams and buffers each channel in its own FIFO. It emits aligned stereo frames {left,right} over a ready/valid handshake, so the recorder writes one coherent frame per SRAM transaction pair. It also guards against channel slip by realigning on a left sample after any desynchronisation.

---
 rtl/audio_pkg.sv | 19 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/stereo_frame_pairer.sv | 130 +++++++++++++
 tb/tb_stereo_frame_pairer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared sample, frame and FSM state types for the stereo capture path.
package audio_pkg;

    localparam int unsigned SampleW = 16;

    typedef logic [SampleW-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        RUN
    } pair_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead sample FIFO with flush and occupancy output.
module sample_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrInc = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        // Same index with differing wrap bits means the write side lapped the read side.
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        level_o = wptr_q - rptr_q;
        head_o  = mem[rptr_q[AW-1:0]];
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PtrInc;
            if (pop_ok)  rptr_q <= rptr_q + PtrInc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/stereo_frame_pairer.sv
// Pairs independent left/right ADC sample streams into {left,right} frames.
// Define STEREO_FRAME_PAIRER_DROP_EN to drop on overflow instead of backpressuring.
module stereo_frame_pairer
    import audio_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_capture,
    input  logic [DW-1:0]          i_left_data,
    input  logic                   i_left_valid,
    output logic                   o_left_ready,
    input  logic [DW-1:0]          i_right_data,
    input  logic                   i_right_valid,
    output logic                   o_right_ready,
    output logic [2*DW-1:0]        o_frame_data,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ready,
    output logic [$clog2(DEPTH):0] o_left_level,
    output logic [$clog2(DEPTH):0] o_right_level,
`ifdef STEREO_FRAME_PAIRER_DROP_EN
    output logic [15:0]            o_drop_cnt,
`endif
    output logic                   o_desync
);

    pair_state_e   state_q;
    logic          in_run;
    logic          in_align;
    logic          slip;
    logic          flush;
    logic          push_l;
    logic          push_r;
    logic          pop;
    logic          full_l;
    logic          full_r;
    logic          empty_l;
    logic          empty_r;
    logic [DW-1:0] head_l;
    logic [DW-1:0] head_r;

    always_comb begin
        in_run        = (state_q == RUN);
        in_align      = (state_q == ALIGN);
        slip          = in_run && ((full_l && empty_r) || (full_r && empty_l));
        flush         = (state_q == IDLE) || !i_capture || slip;
        o_frame_valid = in_run && !empty_l && !empty_r;
        pop           = o_frame_valid && i_frame_ready;
        o_frame_data  = o_frame_valid ? {head_l, head_r} : '0;
        o_desync      = slip;
`ifdef STEREO_FRAME_PAIRER_DROP_EN
        o_left_ready  = 1'b1;
        o_right_ready = 1'b1;
`else
        o_left_ready  = in_run ? !full_l : 1'b1;
        o_right_ready = in_run ? !full_r : 1'b1;
`endif
        // Readies derive only from registered FIFO state, never from i_frame_ready.
        push_l        = i_left_valid && !full_l && (in_run || in_align);
        push_r        = i_right_valid && !full_r && in_run;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else if (!i_capture) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= ALIGN;
                ALIGN:   if (i_left_valid) state_q <= RUN;
                RUN:     if (slip) state_q <= ALIGN;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STEREO_FRAME_PAIRER_DROP_EN
    logic [1:0] drops;

    always_comb begin
        drops = {1'b0, in_run && i_left_valid && full_l}
              + {1'b0, in_run && i_right_valid && full_r};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
        end else if (drops != 2'd0) begin
            if ({1'b0, o_drop_cnt} + {15'd0, drops} > 17'h0FFFF) o_drop_cnt <= 16'hFFFF;
            else o_drop_cnt <= o_drop_cnt + {14'd0, drops};
        end
    end
`endif

    sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_left_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .flush_i     (flush),
        .push_i      (push_l),
        .push_data_i (i_left_data),
        .pop_i       (pop),
        .head_o      (head_l),
        .full_o      (full_l),
        .empty_o     (empty_l),
        .level_o     (o_left_level)
    );

    sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_right_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .flush_i     (flush),
        .push_i      (push_r),
        .push_data_i (i_right_data),
        .pop_i       (pop),
        .head_o      (head_r),
        .full_o      (full_r),
        .empty_o     (empty_r),
        .level_o     (o_right_level)
    );

endmodule

// File: tb/tb_stereo_frame_pairer.sv
// Directed self-checking bench for stereo_frame_pairer (DW=16, DEPTH=8).
module tb_stereo_frame_pairer;

    logic        clk;
    logic        rst_n;
    logic        capture;
    logic [15:0] left_data;
    logic        left_valid;
    logic        left_ready;
    logic [15:0] right_data;
    logic        right_valid;
    logic        right_ready;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  left_level;
    logic [3:0]  right_level;
    logic        desync;
`ifdef STEREO_FRAME_PAIRER_DROP_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    stereo_frame_pairer #(
        .DW    (16),
        .DEPTH (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_capture     (capture),
        .i_left_data   (left_data),
        .i_left_valid  (left_valid),
        .o_left_ready  (left_ready),
        .i_right_data  (right_data),
        .i_right_valid (right_valid),
        .o_right_ready (right_ready),
        .o_frame_data  (frame_data),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready),
        .o_left_level  (left_level),
        .o_right_level (right_level),
`ifdef STEREO_FRAME_PAIRER_DROP_EN
        .o_drop_cnt    (drop_cnt),
`endif
        .o_desync      (desync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [15:0] ld, input logic rv,
                         input logic [15:0] rd);
        left_valid  = lv;
        left_data   = ld;
        right_valid = rv;
        right_data  = rd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_llvl"}, {28'd0, left_level}, 32'd0);
        check_eq({tag, "_rlvl"}, {28'd0, right_level}, 32'd0);
        check_eq({tag, "_fval"}, {31'd0, frame_valid}, 32'd0);
        check_eq({tag, "_fdat"}, frame_data, 32'd0);
        check_eq({tag, "_desync"}, {31'd0, desync}, 32'd0);
        check_eq({tag, "_rdy"}, {30'd0, left_ready, right_ready}, 32'd3);
`ifdef STEREO_FRAME_PAIRER_DROP_EN
        check_eq({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        capture     = 1'b0;
        frame_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        #2;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;

`ifndef STEREO_FRAME_PAIRER_DROP_EN
        // Alignment: leading right sample is discarded.
        capture = 1'b1;
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'h1111);
        tick();
        check_eq("align_rdiscard", {28'd0, right_level}, 32'd0);
        drive(1'b1, 16'hAAAA, 1'b0, 16'h0);
        tick();
        check_eq("align_lpush", {28'd0, left_level}, 32'd1);
        check_eq("align_nofv", {31'd0, frame_valid}, 32'd0);
        drive(1'b0, 16'h0, 1'b1, 16'hBBBB);
        tick();
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("first_fv", {31'd0, frame_valid}, 32'd1);
        check_eq("first_frame", frame_data, 32'hAAAABBBB);
        check_eq("first_desync", {31'd0, desync}, 32'd0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check_eq("first_pop_fv", {31'd0, frame_valid}, 32'd0);
        check_eq("first_pop_lvl", {24'd0, left_level, right_level}, 32'd0);

        // Fill both FIFOs under backpressure, then drain in order.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 1'b1, 16'h2000 + 16'(i));
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("fill_levels", {24'd0, left_level, right_level}, 32'h88);
        check_eq("fill_readies", {30'd0, left_ready, right_ready}, 32'd0);
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain_fv%0d", i), {31'd0, frame_valid}, 32'd1);
            check_eq($sformatf("drain_dat%0d", i), frame_data,
                     {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
            tick();
        end
        frame_ready = 1'b0;
        check_eq("drain_empty", {24'd0, left_level, right_level}, 32'd0);
        check_eq("drain_fv_end", {31'd0, frame_valid}, 32'd0);

        // Left-only slip: desync on the cycle the left FIFO reads full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h3000 + 16'(i), 1'b0, 16'h0);
            tick();
            check_eq($sformatf("slip_desync%0d", i), {31'd0, desync}, (i == 7) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("slip_lfull", {28'd0, left_level}, 32'd8);
        tick();
        check_eq("slip_pulse_end", {31'd0, desync}, 32'd0);
        check_eq("slip_flush", {24'd0, left_level, right_level}, 32'd0);
        drive(1'b0, 16'h0, 1'b1, 16'h4444);
        tick();
        check_eq("slip_in_align", {28'd0, right_level}, 32'd0);

        // Capture drop mid-stream with three frames queued.
        drive(1'b1, 16'h5001, 1'b0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'h6001);
        tick();
        for (int i = 2; i <= 3; i++) begin
            drive(1'b1, 16'h5000 + 16'(i), 1'b1, 16'h6000 + 16'(i));
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("cap_levels", {24'd0, left_level, right_level}, 32'h33);
        check_eq("cap_head", frame_data, 32'h50016001);
        capture = 1'b0;
        tick();
        check_eq("cap_off_lvl", {24'd0, left_level, right_level}, 32'd0);
        check_eq("cap_off_fv", {31'd0, frame_valid}, 32'd0);
        check_eq("cap_off_rdy", {30'd0, left_ready, right_ready}, 32'd3);
        capture = 1'b1;
        tick();

        // Asynchronous reset in the middle of a drain burst.
        drive(1'b1, 16'h7001, 1'b0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'h8001);
        tick();
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 16'h7000 + 16'(i), 1'b1, 16'h8000 + 16'(i));
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        frame_ready = 1'b1;
        tick();
        check_eq("burst_head", frame_data, 32'h70028002);
        check_eq("burst_lvl", {24'd0, left_level, right_level}, 32'h33);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        frame_ready = 1'b0;
        #2 rst_n = 1'b1;
`else
        // Overflow drops: 10 pairs into depth-8 FIFOs with no draining.
        capture = 1'b1;
        tick();
        drive(1'b1, 16'h9000, 1'b0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'hA000);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 16'h9000 + 16'(i), 1'b1, 16'hA000 + 16'(i));
            tick();
            check_eq($sformatf("drop_rdy%0d", i), {30'd0, left_ready, right_ready}, 32'd3);
        end
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("drop_cnt", {16'd0, drop_cnt}, 32'd4);
        check_eq("drop_levels", {24'd0, left_level, right_level}, 32'h88);
        check_eq("drop_desync", {31'd0, desync}, 32'd0);
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drop_fv%0d", i), {31'd0, frame_valid}, 32'd1);
            check_eq($sformatf("drop_dat%0d", i), frame_data,
                     {16'h9000 + 16'(i), 16'hA000 + 16'(i)});
            tick();
        end
        frame_ready = 1'b0;
        check_eq("drop_drained", {24'd0, left_level, right_level}, 32'd0);
        check_eq("drop_cnt_hold", {16'd0, drop_cnt}, 32'd4);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
